// File: rtl/i2c_req_arbiter.sv
// Round-robin scheduler sharing one i2c_master write engine between NUM_REQ requesters.
// Optional transfer watchdog: compile with `define I2C_ARB_WATCHDOG_EN.
module i2c_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [7*NUM_REQ-1:0]   req_addr,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   m_start,
    output logic [6:0]             m_addr,
    output logic [7:0]             m_data,
    input  logic                   m_done,
    output logic                   m_abort
);

    localparam int unsigned      N       = NUM_REQ;
    localparam int               IDX_W   = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] w_gnt_nxt;
    logic [NUM_REQ-1:0] r_done;
    logic [NUM_REQ-1:0] w_done_nxt;
    logic               r_start;
    logic               w_start_nxt;
    logic [6:0]         r_addr;
    logic [6:0]         w_addr_nxt;
    logic [7:0]         r_data;
    logic [7:0]         w_data_nxt;

    logic               w_found;
    logic [31:0]        w_cand;
    logic [IDX_W-1:0]   w_win;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [6:0]         w_win_addr;
    logic [7:0]         w_win_data;
    logic               w_wdog_exp;

    // Winner search starts one past the last served index and wraps.
    always_comb begin
        w_found    = 1'b0;
        w_cand     = '0;
        w_win      = '0;
        w_win_oh   = '0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_cand = (32'(r_ptr) + k) % N;
            if (!w_found && 1'(req >> w_cand)) begin
                w_found    = 1'b1;
                w_win      = IDX_W'(w_cand);
                w_win_oh   = NUM_REQ'(1) << w_cand;
                w_win_addr = 7'(req_addr >> (7 * w_cand));
                w_win_data = 8'(req_data >> (8 * w_cand));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (m_done) begin
                    w_state_nxt = S_RESP;
                end else if (w_wdog_exp) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef I2C_ARB_WATCHDOG_EN
    logic [15:0]        r_wdog;
    logic [NUM_REQ-1:0] r_err;
    logic [NUM_REQ-1:0] w_err_nxt;
    logic               r_abort;
    logic               w_abort_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (r_state == S_START) begin
            r_wdog <= '0;
        end else if (r_state == S_WAIT) begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    assign w_wdog_exp = (r_state == S_WAIT) && (r_wdog >= 16'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_err   <= w_err_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    assign req_err = r_err;
    assign m_abort = r_abort;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYC != 0);
    assign w_wdog_exp       = 1'b0;
    assign req_err          = '0;
    assign m_abort          = 1'b0;
`endif

    always_comb begin
        w_gnt_nxt   = r_gnt;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_idx_nxt   = r_idx;
        w_ptr_nxt   = r_ptr;
        w_start_nxt = 1'b0;
        w_done_nxt  = '0;
`ifdef I2C_ARB_WATCHDOG_EN
        w_err_nxt   = '0;
        w_abort_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gnt_nxt  = w_win_oh;
                    w_idx_nxt  = w_win;
                    w_addr_nxt = w_win_addr;
                    w_data_nxt = w_win_data;
                end
            end
            S_START: w_start_nxt = 1'b1;
            S_WAIT: begin
                // m_done wins over a coincident watchdog expiry.
                if (!m_done && w_wdog_exp) begin
                    w_done_nxt  = r_gnt;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_idx;
`ifdef I2C_ARB_WATCHDOG_EN
                    w_err_nxt   = r_gnt;
                    w_abort_nxt = 1'b1;
`endif
                end
            end
            S_RESP: begin
                w_done_nxt = r_gnt;
                w_gnt_nxt  = '0;
                w_ptr_nxt  = r_idx;
            end
            default: begin
                w_gnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_done  <= '0;
            r_start <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_ptr   <= PTR_RST;
        end else begin
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_start <= w_start_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_idx   <= w_idx_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign req_done = r_done;
    assign m_start  = r_start;
    assign m_addr   = r_addr;
    assign m_data   = r_data;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter against a transaction-level round-robin model.
// Watchdog scenario runs only when I2C_ARB_WATCHDOG_EN is defined.
module tb_i2c_req_arbiter;

    localparam int N   = 4;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [7*N-1:0] req_addr = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic           m_start;
    logic [6:0]     m_addr;
    logic [7:0]     m_data;
    logic           m_done = 1'b0;
    logic           m_abort;

    always #5 clk = ~clk;

    i2c_req_arbiter #(
        .NUM_REQ    (N),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .gnt     (gnt),
        .req_done(req_done),
        .req_err (req_err),
        .m_start (m_start),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .m_done  (m_done),
        .m_abort (m_abort)
    );

    int total = 0;
    int bad   = 0;

    logic [N-1:0] pend = '0;
    int           last = N - 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    function automatic bit has(input logic [N-1:0] v, input int i);
        return 1'(v >> i);
    endfunction

    function automatic logic [6:0] slice_a(input logic [7*N-1:0] v, input int i);
        return 7'(v >> (7 * i));
    endfunction

    function automatic logic [7:0] slice_d(input logic [8*N-1:0] v, input int i);
        return 8'(v >> (8 * i));
    endfunction

    // Round-robin reference: first pending requester after the last one served.
    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (has(pend, (last + k) % N)) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_bus();
        for (int i = 0; i < N; i++) begin
            req_addr = (req_addr & ~((7*N)'(7'h7F) << (7 * i))) | ((7*N)'($urandom_range(0, 127)) << (7 * i));
            req_data = (req_data & ~((8*N)'(8'hFF) << (8 * i))) | ((8*N)'($urandom_range(0, 255)) << (8 * i));
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'(0));
        chk({tag, "_done"}, 32'(req_done), 32'(0));
        chk({tag, "_err"}, 32'(req_err), 32'(0));
        chk({tag, "_start"}, 32'(m_start), 32'(0));
        chk({tag, "_abort"}, 32'(m_abort), 32'(0));
        chk({tag, "_addr"}, 32'(m_addr), 32'(0));
        chk({tag, "_data"}, 32'(m_data), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        req    = '0;
        m_done = 1'b0;
        pend   = '0;
        last   = N - 1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One complete transfer; entered and left at a negedge with the arbiter idle.
    task automatic xfer(input logic [N-1:0] add, input bit drop, input int dly);
        int         w;
        logic [6:0] ea;
        logic [7:0] ed;
        pend = pend | add;
        req  = pend;
        w    = pick();
        ea   = slice_a(req_addr, w);
        ed   = slice_d(req_data, w);
        @(posedge clk); #1;
        chk("grant", 32'(gnt), 32'(oh(w)));
        chk("grant_addr", 32'(m_addr), 32'(ea));
        chk("grant_data", 32'(m_data), 32'(ed));
        chk("grant_nostart", 32'(m_start), 32'(0));
        chk("grant_nodone", 32'(req_done), 32'(0));
        @(negedge clk);
        if (drop) begin
            req      = req & ~oh(w);
            req_addr = ~req_addr;
            req_data = ~req_data;
        end
        @(posedge clk); #1;
        chk("start_pulse", 32'(m_start), 32'(1));
        chk("start_gnt", 32'(gnt), 32'(oh(w)));
        for (int c = 0; c < dly; c++) begin
            @(posedge clk); #1;
            chk("wait_nostart", 32'(m_start), 32'(0));
            chk("wait_gnt", 32'(gnt), 32'(oh(w)));
            chk("wait_addr", 32'(m_addr), 32'(ea));
            chk("wait_data", 32'(m_data), 32'(ed));
            chk("wait_nodone", 32'(req_done), 32'(0));
            chk("wait_noabort", 32'(m_abort), 32'(0));
        end
        @(negedge clk);
        m_done = 1'b1;
        @(posedge clk); #1;
        chk("resp_nodone_yet", 32'(req_done), 32'(0));
        chk("resp_gnt", 32'(gnt), 32'(oh(w)));
        @(negedge clk);
        m_done = 1'b0;
        @(posedge clk); #1;
        chk("req_done", 32'(req_done), 32'(oh(w)));
        chk("gnt_clear", 32'(gnt), 32'(0));
        chk("done_noerr", 32'(req_err), 32'(0));
        chk("done_noabort", 32'(m_abort), 32'(0));
        pend = pend & ~oh(w);
        last = w;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] add;

        #2;
        check_quiet_outputs("reset");
        do_reset();

        // Spurious master done while idle.
        m_done = 1'b1;
        @(posedge clk); #1;
        chk("spur_gnt", 32'(gnt), 32'(0));
        chk("spur_done", 32'(req_done), 32'(0));
        @(negedge clk);
        m_done = 1'b0;
        @(posedge clk); #1;
        chk("spur_start", 32'(m_start), 32'(0));
        chk("spur_done2", 32'(req_done), 32'(0));
        @(negedge clk);

        // Single request on index 1.
        randomize_bus();
        req_addr = (req_addr & ~((7*N)'(7'h7F) << 7)) | ((7*N)'(7'h50) << 7);
        req_data = (req_data & ~((8*N)'(8'hFF) << 8)) | ((8*N)'(8'hA5) << 8);
        xfer(4'b0010, 1'b0, 3);

        // All four requesting continuously from reset.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            randomize_bus();
            xfer({N{1'b1}} & ~pend, 1'b0, $urandom_range(1, 4));
        end
        pend = '0;
        req  = '0;

        // Drop during WAIT and change slices: latched values stand.
        do_reset();
        randomize_bus();
        xfer(4'b0100, 1'b1, 3);

        // Randomized traffic with occasional idle gaps and spurious done.
        for (int t = 0; t < 40; t++) begin
            if (pend == '0 && $urandom_range(0, 3) == 0) begin
                req    = '0;
                m_done = 1'b1;
                @(posedge clk); #1;
                chk("rnd_idle_gnt", 32'(gnt), 32'(0));
                chk("rnd_idle_done", 32'(req_done), 32'(0));
                @(negedge clk);
                m_done = 1'b0;
            end
            randomize_bus();
            add = N'($urandom) & ~pend;
            if ((pend | add) == '0) add = oh($urandom_range(0, N - 1));
            xfer(add, $urandom_range(0, 3) == 0, $urandom_range(1, 6));
        end

        // Asynchronous reset during WAIT.
        pend = '0;
        req  = '0;
        @(negedge clk);
        req = 4'b0001;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_quiet_outputs("async_rst");
        @(negedge clk);
        req  = '0;
        pend = '0;
        last = N - 1;
        @(posedge clk); #1;
        chk("rst_hold_done", 32'(req_done), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        randomize_bus();
        xfer(4'b1000, 1'b0, 2);

`ifdef I2C_ARB_WATCHDOG_EN
        do_reset();
        req = 4'b0011;
        @(posedge clk); #1;
        chk("wd_grant", 32'(gnt), 32'(4'b0001));
        @(posedge clk); #1;
        chk("wd_start", 32'(m_start), 32'(1));
        for (int c = 0; c < TMO; c++) begin
            @(posedge clk); #1;
            chk("wd_pending", 32'({m_abort, req_done}), 32'(0));
        end
        @(posedge clk); #1;
        chk("wd_abort", 32'(m_abort), 32'(1));
        chk("wd_err", 32'(req_err), 32'(4'b0001));
        chk("wd_done", 32'(req_done), 32'(4'b0001));
        chk("wd_gnt_clr", 32'(gnt), 32'(0));
        @(negedge clk);
        pend = 4'b0010;
        last = 0;
        randomize_bus();
        xfer('0, 1'b0, 2);
`else
        do_reset();
        randomize_bus();
        xfer(4'b0001, 1'b0, 3 * TMO);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin scheduler that shares one `i2c_master` write engine between `NUM_REQ` independent requesters. Each requester posts a 7-bit target address and one data byte. The arbiter picks one requester fairly, drives the master's `start`/`addr`/`data` inputs, waits for the master's `done`, and returns a per-requester completion pulse. It sits between the system-side register blocks and the single `i2c_master` instance. An optional watchdog aborts a hung transfer.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYC`, default 1023: watchdog limit in clk cycles for one transfer. Used only when the watchdog is compiled in.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req` input NUM_REQ: level request. Bit i must be held until `req_done[i]`.
- `req_addr` input 7*NUM_REQ: slice i = `req_addr[7*i +: 7]`.
- `req_data` input 8*NUM_REQ: slice i = `req_data[8*i +: 8]`.
- `gnt` output NUM_REQ: one-hot grant, held for the whole transfer.
- `req_done` output NUM_REQ: one-cycle one-hot completion pulse.
- `req_err` output NUM_REQ: one-cycle pulse, coincident with `req_done`, on watchdog abort.
- `m_start` output 1: to master `start`. One-cycle pulse.
- `m_addr` output 7: to master `addr`. Registered, stable from grant until done.
- `m_data` output 8: to master `data`. Registered, stable from grant until done.
- `m_done` input 1: from master `done`, one-cycle pulse.
- `m_abort` output 1: one-cycle pulse. The integrator ORs it into the master reset.

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE**: if `req != 0`, select the winner, register `gnt` one-hot, `m_addr` and `m_data` from the winner's slices, then go to START. Otherwise stay in IDLE.
- **Winner selection**: round-robin. Search begins at index `ptr+1` and wraps modulo NUM_REQ. `ptr` resets to NUM_REQ-1, so the first search starts at index 0.
- **START**: `m_start`=1 for exactly one cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT**: hold `gnt`, `m_addr` and `m_data`. When `m_done`=1, go to RESP.
- **RESP**: pulse `req_done[winner]`, clear `gnt`, set `ptr`=winner, go to IDLE.
- Dropping `req[winner]` after grant does not cancel the transfer. It still completes and `req_done` still pulses.
- A change on `req_addr` or `req_data` after grant is ignored.
- `m_done` arriving outside WAIT is ignored.
- A requester re-asserting immediately after its own `req_done` is served after all other pending requesters (fairness).
- Reset mid-transfer:
  - Every output returns to its reset value at once; `ptr` returns to NUM_REQ-1.
  - No `req_done` is issued.
  - `m_abort` is not driven; the master shares `rst_n`.

## Timing
- Reset values: `gnt`=0, `req_done`=0, `req_err`=0, `m_start`=0, `m_addr`=0, `m_data`=0, `m_abort`=0, state=IDLE.
- All outputs are registered.
- `req` sampled high at edge N in IDLE: `gnt`/`m_addr`/`m_data` valid after N, `m_start` high for the cycle after N+1.
- `m_done` sampled at edge M: `req_done` high for the cycle after M+1, `gnt` low after M+1.
- Next grant earliest at edge M+2.
- Arbitration overhead is 3 cycles per transfer, excluding master time.

## Configuration
- Macro: `I2C_ARB_WATCHDOG_EN`.
- **Defined**:
  - A 16-bit counter increments each cycle in WAIT.
  - If it reaches `TIMEOUT_CYC` without `m_done`, then in the next cycle `m_abort`=1, `req_err[winner]`=1 and `req_done[winner]`=1, and the arbiter goes to IDLE with `ptr` updated.
- **Not defined**:
  - No counter exists.
  - `m_abort` and `req_err` are tied to 0.
  - WAIT exits only on `m_done`.

## Test plan
- Single request: `req`=4'b0010, slice 1 addr=7'h50, data=8'hA5 → `gnt`=4'b0010, `m_addr`=7'h50, `m_data`=8'hA5, one `m_start` pulse, `req_done`=4'b0010 one cycle after the master `done`.
- All four requesting continuously → grant order 0,1,2,3,0; every `gnt` is one-hot; no starvation over 8 transfers.
- `req[2]` dropped during WAIT, `req_data` slice changed → transfer completes with the originally latched data; `req_done[2]` pulses.
- `rst_n` low during WAIT → all outputs 0 asynchronously; after release, a fresh `req`=4'b1000 is granted to index 3 with a correct `m_start`.
- Watchdog enabled, `TIMEOUT_CYC`=20, master held in reset (never done) → `m_abort`, `req_err[0]` and `req_done[0]` pulse together 21 cycles after `m_start`; the next requester is granted afterwards.
- Spurious `m_done` pulse in IDLE → no state change, no `req_done`.
